// File: rtl/usb_rx_ctrl.sv
// USB full-speed packet receive controller: checks SYNC/PID/length, streams DATA payload
// into the RX FIFO while holding back the last two bytes (CRC16), and reports status.
module usb_rx_ctrl (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       byte_valid,
  input  logic [7:0] rx_byte,
  input  logic       eop,
  input  logic       bit_err,
  input  logic [6:0] buffer_occupancy,
  output logic [2:0] rx_packet,
  output logic       rx_data_ready,
  output logic       rx_transfer_active,
  output logic       rx_error,
  output logic       flush,
  output logic       store_rx_packet_data,
  output logic [7:0] rx_packet_data,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_PID, S_TOKEN, S_DATA, S_HSHAKE, S_ERR_WAIT
  } state_t;

  // Handshake: byte_valid/eop/bit_err are single-cycle pulses with no back-pressure;
  // every output is a registered response visible the cycle after the pulse.

  state_t     state, state_d, mid_state;
  logic [1:0] cnt, cnt_mid, cnt_d;
  logic [1:0] fill, fill_mid, fill_d;
  logic [7:0] h0, h1, h0_d, h1_d;
  logic       byte_ev, line_err, byte_err, eop_ev, eop_err, err_any;
  logic       sync_ok, store_now, pid_ok;
  logic [2:0] pid_code;

  logic [2:0] pkt_d;
  logic       ready_d, active_d, err_d, flush_d, store_d;
  logic [7:0] data_d;

  assign dbg_state = state;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next state: the byte is applied first, then eop against the updated state/count/fill.
  always_comb begin
    byte_ev   = byte_valid & ((state == S_IDLE) | ~bit_err);
    line_err  = bit_err & (state != S_IDLE) & (state != S_ERR_WAIT);
    pid_ok    = (rx_byte[7:4] == ~rx_byte[3:0]);
    case (rx_byte[3:0])
      4'b0001: pid_code = 3'd1;
      4'b1001: pid_code = 3'd2;
      4'b0011: pid_code = 3'd3;
      4'b1011: pid_code = 3'd4;
      4'b0010: pid_code = 3'd5;
      4'b1010: pid_code = 3'd6;
      4'b1110: pid_code = 3'd7;
      default: pid_code = 3'd0;
    endcase
    if (!pid_ok) pid_code = 3'd0;

    mid_state = state;
    cnt_mid   = cnt;
    fill_mid  = fill;
    byte_err  = 1'b0;
    sync_ok   = 1'b0;
    store_now = 1'b0;
    if (line_err) begin
      mid_state = S_ERR_WAIT;
    end else if (byte_ev) begin
      case (state)
        S_IDLE:
          if (rx_byte == 8'h80) begin
            sync_ok   = 1'b1;
            mid_state = S_PID;
          end else begin
            byte_err = 1'b1;
          end
        S_PID:
          case (pid_code)
            3'd1, 3'd2:       mid_state = S_TOKEN;
            3'd3, 3'd4:       mid_state = S_DATA;
            3'd5, 3'd6, 3'd7: mid_state = S_HSHAKE;
            default:          byte_err  = 1'b1;
          endcase
        S_TOKEN:
          if (cnt == 2'd2) byte_err = 1'b1;
          else             cnt_mid  = cnt + 2'd1;
        S_HSHAKE: byte_err = 1'b1;
        S_DATA:
          if (fill == 2'd2) begin
            if (buffer_occupancy >= 7'd64) byte_err  = 1'b1;
            else                           store_now = 1'b1;
          end else begin
            fill_mid = fill + 2'd1;
          end
        default: ;
      endcase
      if (byte_err) mid_state = S_ERR_WAIT;
    end

    // Every eop seen outside IDLE ends the packet, successfully or not.
    eop_ev  = eop & (mid_state != S_IDLE);
    eop_err = 1'b0;
    if (eop_ev) begin
      case (mid_state)
        S_PID:   eop_err = 1'b1;
        S_TOKEN: eop_err = (cnt_mid != 2'd2);
        S_DATA:  eop_err = (fill_mid != 2'd2);
        default: ;
      endcase
    end
    err_any = line_err | byte_err | eop_err;
    state_d = eop_ev ? S_IDLE : mid_state;
  end

  // Registered output and datapath values.
  always_comb begin
    pkt_d   = rx_packet;
    flush_d = 1'b0;
    if (!line_err && byte_ev && state == S_PID && pid_code != 3'd0) begin
      pkt_d   = pid_code;
      flush_d = (pid_code == 3'd3) || (pid_code == 3'd4);
    end
    store_d = store_now;
    data_d  = store_now ? h0 : rx_packet_data;
    ready_d = eop_ev && !eop_err && (mid_state == S_DATA);

    err_d = rx_error;
    if (sync_ok) err_d = 1'b0;
    if (err_any) err_d = 1'b1;

    active_d = rx_transfer_active;
    if (err_any)      active_d = 1'b0;
    else if (flush_d) active_d = 1'b1;
    else if (ready_d) active_d = 1'b0;

    h0_d = h0;
    h1_d = h1;
    if (!line_err && !byte_err && byte_ev && state == S_DATA) begin
      case (fill)
        2'd0:    h0_d = rx_byte;
        2'd1:    h1_d = rx_byte;
        default: begin
          h0_d = h1;
          h1_d = rx_byte;
        end
      endcase
    end
    cnt_d  = (state_d == S_TOKEN) ? cnt_mid : 2'd0;
    fill_d = (state_d == S_DATA) ? fill_mid : 2'd0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_packet            <= 3'd0;
      rx_data_ready        <= 1'b0;
      rx_transfer_active   <= 1'b0;
      rx_error             <= 1'b0;
      flush                <= 1'b0;
      store_rx_packet_data <= 1'b0;
      rx_packet_data       <= 8'h00;
      cnt                  <= 2'd0;
      fill                 <= 2'd0;
      h0                   <= 8'h00;
      h1                   <= 8'h00;
    end else begin
      rx_packet            <= pkt_d;
      rx_data_ready        <= ready_d;
      rx_transfer_active   <= active_d;
      rx_error             <= err_d;
      flush                <= flush_d;
      store_rx_packet_data <= store_d;
      rx_packet_data       <= data_d;
      cnt                  <= cnt_d;
      fill                 <= fill_d;
      h0                   <= h0_d;
      h1                   <= h1_d;
    end
  end

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Bench for usb_rx_ctrl: directed packets with literal expectations plus random packets
// checked cycle by cycle against a packet-level model built on a byte queue.
module tb_usb_rx_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       eop = 1'b0;
  logic       bit_err = 1'b0;
  logic [6:0] occ = 7'd0;
  logic [2:0] rx_packet;
  logic       rx_data_ready, rx_transfer_active, rx_error, flush, store_rx_packet_data;
  logic [7:0] rx_packet_data;
  logic [2:0] dbg_state;

  usb_rx_ctrl dut (
    .clk(clk), .n_rst(n_rst), .byte_valid(byte_valid), .rx_byte(rx_byte), .eop(eop),
    .bit_err(bit_err), .buffer_occupancy(occ), .rx_packet(rx_packet),
    .rx_data_ready(rx_data_ready), .rx_transfer_active(rx_transfer_active),
    .rx_error(rx_error), .flush(flush), .store_rx_packet_data(store_rx_packet_data),
    .rx_packet_data(rx_packet_data), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- model ----------------
  localparam int P_IDLE = 0, P_PID = 1, P_TOK = 2, P_DATA = 3, P_HS = 4, P_DISC = 5;
  int         m_phase;
  logic [2:0] e_pkt;
  logic       e_err, e_act, e_flush, e_store, e_ready;
  logic [7:0] pkt_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];

  bit         chk_en = 1'b0;
  int         n_flush = 0, n_store = 0, n_ready = 0;
  logic [7:0] st_log[$];

  function automatic logic [2:0] pid_lookup(logic [7:0] b);
    case (b)
      8'hE1: return 3'd1;
      8'h69: return 3'd2;
      8'hC3: return 3'd3;
      8'h4B: return 3'd4;
      8'hD2: return 3'd5;
      8'h5A: return 3'd6;
      8'h1E: return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%02h expected=%02h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    e_pkt = 3'd0; e_err = 1'b0; e_act = 1'b0;
    e_flush = 1'b0; e_store = 1'b0; e_ready = 1'b0;
    pkt_q.delete();
    exp_q.delete();
  endtask

  task automatic model_fail();
    e_err = 1'b1;
    e_act = 1'b0;
    pkt_q.delete();
    m_phase = P_DISC;
  endtask

  // Expected outputs after the clock edge that samples these inputs.
  task automatic model_step(bit bv, logic [7:0] b, bit e, bit be);
    logic [2:0] code;
    e_flush = 1'b0; e_store = 1'b0; e_ready = 1'b0;
    if (be && m_phase != P_IDLE && m_phase != P_DISC) begin
      model_fail();
      if (e) m_phase = P_IDLE;
      return;
    end
    if (bv) begin
      case (m_phase)
        P_IDLE:
          if (b == 8'h80) begin e_err = 1'b0; m_phase = P_PID; end
          else model_fail();
        P_PID: begin
          code = pid_lookup(b);
          if (code == 3'd0) model_fail();
          else begin
            e_pkt = code;
            pkt_q.delete();
            if (code <= 3'd2) m_phase = P_TOK;
            else if (code <= 3'd4) begin e_flush = 1'b1; e_act = 1'b1; m_phase = P_DATA; end
            else m_phase = P_HS;
          end
        end
        P_TOK:
          if (pkt_q.size() == 2) model_fail();
          else pkt_q.push_back(b);
        P_HS: model_fail();
        P_DATA: begin
          pkt_q.push_back(b);
          if (pkt_q.size() >= 3) begin
            if (occ >= 7'd64) model_fail();
            else begin
              e_store = 1'b1;
              exp_q.push_back(pkt_q[pkt_q.size() - 3]);
            end
          end
        end
        default: ;
      endcase
    end
    if (e && m_phase != P_IDLE) begin
      case (m_phase)
        P_PID:  model_fail();
        P_TOK:  if (pkt_q.size() != 2) model_fail();
        P_DATA: if (pkt_q.size() >= 2) begin e_ready = 1'b1; e_act = 1'b0; end
                else model_fail();
        default: ;
      endcase
      m_phase = P_IDLE;
    end
  endtask

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("rx_packet", {5'd0, rx_packet}, {5'd0, e_pkt});
      chk("rx_error", {7'd0, rx_error}, {7'd0, e_err});
      chk("rx_transfer_active", {7'd0, rx_transfer_active}, {7'd0, e_act});
      chk("flush", {7'd0, flush}, {7'd0, e_flush});
      chk("store", {7'd0, store_rx_packet_data}, {7'd0, e_store});
      chk("rx_data_ready", {7'd0, rx_data_ready}, {7'd0, e_ready});
      if (e_store && exp_q.size() > 0) chk("store_data", rx_packet_data, exp_q.pop_front());
    end
    if (flush) n_flush++;
    if (rx_data_ready) n_ready++;
    if (store_rx_packet_data) begin
      n_store++;
      st_log.push_back(rx_packet_data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(bit bv, logic [7:0] b, bit e, bit be);
    @(negedge clk);
    byte_valid = bv; rx_byte = b; eop = e; bit_err = be;
    model_step(bv, b, e, be);
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic send_byte(logic [7:0] b);
    drive(1'b1, b, 1'b0, 1'b0);
    idle($urandom_range(0, 2));
  endtask

  task automatic send_eop();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    n_rst = 1'b0;
    byte_valid = 1'b0; eop = 1'b0; bit_err = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    model_step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int f0, s0, r0, li, kind, n;
    bit combine, be;
    model_reset();
    chk_en = 1'b1;
    reset_dut();
    idle(1);
    chk("lit_reset_packet", {5'd0, rx_packet}, 8'd0);
    chk("lit_reset_error", {7'd0, rx_error}, 8'd0);
    chk("lit_reset_active", {7'd0, rx_transfer_active}, 8'd0);

    // OUT token
    f0 = n_flush; s0 = n_store;
    send_byte(8'h80); send_byte(8'hE1); send_byte(8'hA5); send_byte(8'h5B); send_eop();
    chk("lit_token_packet", {5'd0, rx_packet}, 8'd1);
    chk("lit_token_error", {7'd0, rx_error}, 8'd0);
    chk("lit_token_no_flush", 8'(n_flush - f0), 8'd0);
    chk("lit_token_no_store", 8'(n_store - s0), 8'd0);

    // DATA0 with 4 payload bytes
    f0 = n_flush; s0 = n_store; r0 = n_ready; li = st_log.size();
    send_byte(8'h80); send_byte(8'hC3);
    chk("lit_data_active", {7'd0, rx_transfer_active}, 8'd1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'hAA); send_byte(8'hBB); send_eop();
    chk("lit_data_flush", 8'(n_flush - f0), 8'd1);
    chk("lit_data_stores", 8'(n_store - s0), 8'd4);
    if (st_log.size() >= li + 4) begin
      chk("lit_data_b0", st_log[li], 8'h11);
      chk("lit_data_b1", st_log[li + 1], 8'h22);
      chk("lit_data_b2", st_log[li + 2], 8'h33);
      chk("lit_data_b3", st_log[li + 3], 8'h44);
    end
    chk("lit_data_ready", 8'(n_ready - r0), 8'd1);
    chk("lit_data_active_end", {7'd0, rx_transfer_active}, 8'd0);
    chk("lit_data_packet", {5'd0, rx_packet}, 8'd3);

    // Bad PID, ignored bytes, recovery on next SYNC
    send_byte(8'h80); send_byte(8'hE2); idle(1);
    chk("lit_badpid_error", {7'd0, rx_error}, 8'd1);
    chk("lit_badpid_packet", {5'd0, rx_packet}, 8'd3);
    send_byte(8'h01); send_byte(8'h02); send_eop();
    send_byte(8'h80); idle(1);
    chk("lit_resync_error", {7'd0, rx_error}, 8'd0);
    send_byte(8'h5A); send_eop();
    chk("lit_nak_packet", {5'd0, rx_packet}, 8'd6);

    // Overflow during DATA1
    occ = 7'd64; s0 = n_store; r0 = n_ready;
    send_byte(8'h80); send_byte(8'h4B); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    idle(1);
    chk("lit_ovf_error", {7'd0, rx_error}, 8'd1);
    chk("lit_ovf_active", {7'd0, rx_transfer_active}, 8'd0);
    chk("lit_ovf_no_store", 8'(n_store - s0), 8'd0);
    send_eop();
    chk("lit_ovf_no_ready", 8'(n_ready - r0), 8'd0);
    occ = 7'd0;

    // Short data, then ACK followed by a byte
    s0 = n_store;
    send_byte(8'h80); send_byte(8'h4B); send_byte(8'h55); send_eop();
    chk("lit_short_error", {7'd0, rx_error}, 8'd1);
    chk("lit_short_no_store", 8'(n_store - s0), 8'd0);
    send_byte(8'h80); send_byte(8'hD2); idle(1);
    chk("lit_ack_ok", {7'd0, rx_error}, 8'd0);
    chk("lit_ack_packet", {5'd0, rx_packet}, 8'd5);
    send_byte(8'h01); idle(1);
    chk("lit_ack_extra_error", {7'd0, rx_error}, 8'd1);
    send_eop();

    // bit_err after 3 payload bytes, then reset mid-packet
    s0 = n_store;
    send_byte(8'h80); send_byte(8'hC3); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    drive(1'b0, 8'h00, 1'b0, 1'b1); idle(1);
    chk("lit_biterr_error", {7'd0, rx_error}, 8'd1);
    chk("lit_biterr_active", {7'd0, rx_transfer_active}, 8'd0);
    chk("lit_biterr_stores", 8'(n_store - s0), 8'd1);
    send_eop();
    send_byte(8'h80); send_byte(8'h4B); send_byte(8'h09);
    reset_dut(); idle(1);
    chk("lit_rst_packet", {5'd0, rx_packet}, 8'd0);
    chk("lit_rst_error", {7'd0, rx_error}, 8'd0);
    chk("lit_rst_active", {7'd0, rx_transfer_active}, 8'd0);
    send_byte(8'h80); send_byte(8'h69); send_byte(8'h12); send_byte(8'h34); send_eop();
    chk("lit_after_rst_packet", {5'd0, rx_packet}, 8'd2);
    chk("lit_after_rst_error", {7'd0, rx_error}, 8'd0);

    // Random packets
    for (int p = 0; p < 400; p++) begin
      occ = ($urandom_range(0, 15) == 0) ? 7'd64 : 7'($urandom_range(0, 63));
      kind = $urandom_range(0, 9);
      tx_q.delete();
      case (kind)
        0, 1: begin
          tx_q.push_back(8'h80);
          tx_q.push_back($urandom_range(0, 1) ? 8'hE1 : 8'h69);
          n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 2;
          repeat (n) tx_q.push_back(8'($urandom));
        end
        2, 3, 4, 5: begin
          tx_q.push_back(8'h80);
          tx_q.push_back($urandom_range(0, 1) ? 8'hC3 : 8'h4B);
          repeat ($urandom_range(0, 12)) tx_q.push_back(8'($urandom));
        end
        6: begin
          tx_q.push_back(8'h80);
          n = $urandom_range(0, 2);
          tx_q.push_back(n == 0 ? 8'hD2 : (n == 1 ? 8'h5A : 8'h1E));
          if ($urandom_range(0, 3) == 0) tx_q.push_back(8'($urandom));
        end
        7: repeat (3) tx_q.push_back(8'($urandom));
        default: begin
          tx_q.push_back(8'h80);
          repeat (3) tx_q.push_back(8'($urandom));
        end
      endcase
      combine = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < tx_q.size(); i++) begin
        be = ($urandom_range(0, 59) == 0);
        if (i == tx_q.size() - 1 && combine) drive(1'b1, tx_q[i], 1'b1, be);
        else begin
          drive(1'b1, tx_q[i], 1'b0, be);
          idle($urandom_range(0, 2));
        end
        if ($urandom_range(0, 79) == 0) drive(1'b0, 8'h00, 1'b0, 1'b1);
        if ($urandom_range(0, 199) == 0) reset_dut();
      end
      if (!combine) drive(1'b0, 8'h00, 1'b1, 1'b0);
      idle($urandom_range(1, 3));
    end
    idle(3);
    chk("exp_q_drained", 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
